// File: rtl/enet_rx_frame_filter.sv
// Receive frame filter: buffers each frame in a packet FIFO, filters on
// destination MAC, drops runt / bad-CRC / overflowing frames, and releases
// only committed frames on a valid/ready output stream.
module enet_rx_frame_filter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  input  logic [31:0]       in_data_i,
  input  logic [3:0]        in_strb_i,
  input  logic              in_last_i,
  input  logic              in_crc_valid_i,
  input  logic [47:0]       mac_addr_i,
  input  logic              promisc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic [3:0]        out_strb_o,
  output logic              out_last_o,
  output logic [CNT_W-1:0]  stat_ok_o,
  output logic [CNT_W-1:0]  stat_crc_o,
  output logic [CNT_W-1:0]  stat_addr_o,
  output logic [CNT_W-1:0]  stat_ovf_o
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_STORE, S_DROP} state_t;

  typedef struct packed {
    logic        last;
    logic [3:0]  strb;
    logic [31:0] data;
  } rx_word_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rx_word_t           mem_q [DEPTH];
  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   fetch_ptr_q, fetch_ptr_d;
  logic [31:0]        hdr_q, hdr_d;
  logic [CNT_W-1:0]   stat_ok_q, stat_ok_d;
  logic [CNT_W-1:0]   stat_crc_q, stat_crc_d;
  logic [CNT_W-1:0]   stat_addr_q, stat_addr_d;
  logic [CNT_W-1:0]   stat_ovf_q, stat_ovf_d;
  logic               s1_vld_q, s1_vld_d;
  rx_word_t           s1_word_q;
  logic               out_vld_q, out_vld_d;
  rx_word_t           out_word_q, out_word_d;

  logic               wen_c;
  logic               full_c;
  logic               addr_ok_c;
  logic [47:0]        da_c;
  logic [PTR_W-1:0]   wr_inc_c;
  rx_word_t           in_word_c;
  logic               pop_c;
  logic               s1_move_c;
  logic               fetch_c;

  assign in_word_c = '{last: in_last_i, strb: in_strb_i, data: in_data_i};
  assign wr_inc_c  = wr_ptr_q + PTR_W'(1);
  // Occupancy counts everything not yet popped, including prefetched words.
  assign full_c    = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
  // Destination address reassembled in wire order: first byte is [47:40].
  assign da_c      = {hdr_q[7:0], hdr_q[15:8], hdr_q[23:16], hdr_q[31:24],
                      in_data_i[7:0], in_data_i[15:8]};
  assign addr_ok_c = promisc_i || (da_c == mac_addr_i) || (&da_c);

  // Write-side FSM: speculative write, commit on good last, roll back otherwise.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    hdr_d        = hdr_q;
    stat_ok_d    = stat_ok_q;
    stat_crc_d   = stat_crc_q;
    stat_addr_d  = stat_addr_q;
    stat_ovf_d   = stat_ovf_q;
    wen_c        = 1'b0;
    if (in_valid_i) begin
      if (state_q != S_DROP && full_c) begin
        wr_ptr_d   = commit_ptr_q;
        stat_ovf_d = sat_inc(stat_ovf_q);
        state_d    = in_last_i ? S_IDLE : S_DROP;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            wen_c = 1'b1;
            hdr_d = in_data_i;
            if (in_last_i) begin
              wr_ptr_d    = commit_ptr_q;
              stat_addr_d = sat_inc(stat_addr_q);
            end else begin
              wr_ptr_d = wr_inc_c;
              state_d  = S_HDR;
            end
          end
          S_HDR, S_STORE: begin
            if (state_q == S_HDR && !addr_ok_c) begin
              wr_ptr_d    = commit_ptr_q;
              stat_addr_d = sat_inc(stat_addr_q);
              state_d     = in_last_i ? S_IDLE : S_DROP;
            end else begin
              wen_c = 1'b1;
              if (in_last_i) begin
                state_d = S_IDLE;
                if (in_crc_valid_i) begin
                  wr_ptr_d     = wr_inc_c;
                  commit_ptr_d = wr_inc_c;
                  stat_ok_d    = sat_inc(stat_ok_q);
                end else begin
                  wr_ptr_d   = commit_ptr_q;
                  stat_crc_d = sat_inc(stat_crc_q);
                end
              end else begin
                wr_ptr_d = wr_inc_c;
                state_d  = S_STORE;
              end
            end
          end
          S_DROP: begin
            if (in_last_i) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign pop_c     = out_vld_q && out_ready_i;
  assign s1_move_c = s1_vld_q && (!out_vld_q || pop_c);
  assign fetch_c   = (fetch_ptr_q != commit_ptr_q) && (!s1_vld_q || s1_move_c);

  // Read side: RAM read stage feeding a one-entry output register.
  always_comb begin
    fetch_ptr_d = fetch_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    s1_vld_d    = s1_vld_q;
    out_vld_d   = out_vld_q;
    out_word_d  = out_word_q;
    if (fetch_c) begin
      fetch_ptr_d = fetch_ptr_q + PTR_W'(1);
      s1_vld_d    = 1'b1;
    end else if (s1_move_c) begin
      s1_vld_d = 1'b0;
    end
    if (pop_c) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      out_vld_d = 1'b0;
    end
    if (s1_move_c) begin
      out_vld_d  = 1'b1;
      out_word_d = s1_word_q;
    end
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      hdr_q        <= '0;
      stat_ok_q    <= '0;
      stat_crc_q   <= '0;
      stat_addr_q  <= '0;
      stat_ovf_q   <= '0;
      s1_vld_q     <= 1'b0;
      out_vld_q    <= 1'b0;
      out_word_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      hdr_q        <= hdr_d;
      stat_ok_q    <= stat_ok_d;
      stat_crc_q   <= stat_crc_d;
      stat_addr_q  <= stat_addr_d;
      stat_ovf_q   <= stat_ovf_d;
      s1_vld_q     <= s1_vld_d;
      out_vld_q    <= out_vld_d;
      out_word_q   <= out_word_d;
    end
  end

  // Packet RAM: one write port, one registered read port.
  always_ff @(posedge clk_i) begin
    if (wen_c) mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_word_c;
    if (fetch_c) s1_word_q <= mem_q[fetch_ptr_q[ADDR_W-1:0]];
  end

  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_word_q.data;
  assign out_strb_o  = out_word_q.strb;
  assign out_last_o  = out_word_q.last;
  assign stat_ok_o   = stat_ok_q;
  assign stat_crc_o  = stat_crc_q;
  assign stat_addr_o = stat_addr_q;
  assign stat_ovf_o  = stat_ovf_q;

endmodule

// File: tb/tb_enet_rx_frame_filter.sv
// Bench for enet_rx_frame_filter: a default-depth instance and a 16-word
// instance share the input stream; a scoreboard checks released words.
module tb_enet_rx_frame_filter;

  localparam int unsigned CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, in_crc, promisc, out_ready, sel_small;
  logic [31:0] in_data;
  logic [3:0]  in_strb;
  logic [47:0] mac;

  logic             b_valid, b_last, s_valid, s_last;
  logic [31:0]      b_data, s_data;
  logic [3:0]       b_strb, s_strb;
  logic [CNT_W-1:0] b_ok, b_crc, b_addr, b_ovf, s_ok, s_crc, s_addr, s_ovf;

  int checks = 0;
  int failures = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  enet_rx_frame_filter #(.ADDR_W(9), .CNT_W(CNT_W)) u_dut_big (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid & ~sel_small),
    .in_data_i(in_data), .in_strb_i(in_strb), .in_last_i(in_last),
    .in_crc_valid_i(in_crc), .mac_addr_i(mac), .promisc_i(promisc),
    .out_valid_o(b_valid), .out_ready_i(out_ready), .out_data_o(b_data),
    .out_strb_o(b_strb), .out_last_o(b_last), .stat_ok_o(b_ok),
    .stat_crc_o(b_crc), .stat_addr_o(b_addr), .stat_ovf_o(b_ovf));

  enet_rx_frame_filter #(.ADDR_W(4), .CNT_W(CNT_W)) u_dut_small (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid & sel_small),
    .in_data_i(in_data), .in_strb_i(in_strb), .in_last_i(in_last),
    .in_crc_valid_i(in_crc), .mac_addr_i(mac), .promisc_i(promisc),
    .out_valid_o(s_valid), .out_ready_i(out_ready), .out_data_o(s_data),
    .out_strb_o(s_strb), .out_last_o(s_last), .stat_ok_o(s_ok),
    .stat_crc_o(s_crc), .stat_addr_o(s_addr), .stat_ovf_o(s_ovf));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mon_word(input logic [36:0] w);
    logic [36:0] e;
    check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val("out_word", 64'(w), 64'(e));
    end
  endtask

  // Output monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_valid && out_ready) mon_word({b_last, b_strb, b_data});
      if (s_valid && out_ready) mon_word({s_last, s_strb, s_data});
    end
  end

  task automatic drive_word(input logic [31:0] d, input logic [3:0] s, input logic l, input logic c);
    in_valid = 1'b1; in_data = d; in_strb = s; in_last = l; in_crc = c;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_crc = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] da, input int n, input logic [3:0] lstrb,
                            input logic crc_ok, input logic pass);
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    for (int i = 0; i < n; i++) begin
      if (i == 0)      d = {da[23:16], da[31:24], da[39:32], da[47:40]};
      else if (i == 1) d = {16'($urandom), da[7:0], da[15:8]};
      else             d = $urandom;
      l = (i == n - 1);
      s = l ? lstrb : 4'hF;
      if (pass) sb.push_back({l, s, d});
      drive_word(d, s, l, crc_ok);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    #1;
    check_val("drain", 64'(sb.size()), 64'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  localparam logic [47:0] MAC_ME = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_OT = 48'h02_00_00_00_00_02;
  localparam logic [47:0] MAC_BC = 48'hFF_FF_FF_FF_FF_FF;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_crc = 1'b0; promisc = 1'b0;
    out_ready = 1'b1; sel_small = 1'b0; in_data = '0; in_strb = '0; mac = MAC_ME;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_b_valid", 64'(b_valid), 64'd0);
    check_val("rst_s_valid", 64'(s_valid), 64'd0);
    check_val("rst_b_stats", 64'({b_ok, b_crc, b_addr, b_ovf}), 64'd0);
    check_val("rst_s_stats", 64'({s_ok, s_crc, s_addr, s_ovf}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unicast good frame plus commit-to-valid latency.
    send_frame(MAC_ME, 16, 4'hF, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_val("lat1", 64'(b_valid), 64'd0);
    @(posedge clk); #1;
    check_val("lat2", 64'(b_valid), 64'd1);
    wait_drain();
    check_val("uni_ok", 64'(b_ok), 64'd1);

    // Bad CRC frame followed directly by a good one.
    send_frame(MAC_ME, 8, 4'hF, 1'b0, 1'b0);
    send_frame(MAC_ME, 8, 4'hF, 1'b1, 1'b1);
    wait_drain();
    check_val("crc_cnt", 64'(b_crc), 64'd1);
    check_val("crc_ok", 64'(b_ok), 64'd2);

    // Address filter, promiscuous and broadcast.
    send_frame(MAC_OT, 6, 4'hF, 1'b1, 1'b0);
    wait_drain();
    check_val("flt_addr", 64'(b_addr), 64'd1);
    check_val("flt_ok", 64'(b_ok), 64'd2);
    promisc = 1'b1;
    send_frame(MAC_OT, 6, 4'hF, 1'b1, 1'b1);
    wait_drain();
    promisc = 1'b0;
    check_val("prm_ok", 64'(b_ok), 64'd3);
    send_frame(MAC_BC, 5, 4'hF, 1'b1, 1'b1);
    wait_drain();
    check_val("bc_ok", 64'(b_ok), 64'd4);

    // Runt single word, then partial last word.
    send_frame(MAC_ME, 1, 4'hF, 1'b1, 1'b0);
    wait_drain();
    check_val("runt_addr", 64'(b_addr), 64'd2);
    send_frame(MAC_ME, 7, 4'b0011, 1'b1, 1'b1);
    wait_drain();
    check_val("strb_ok", 64'(b_ok), 64'd5);
    check_val("strb_crc", 64'(b_crc), 64'd1);

    // Reset at word 5 of a frame in STORE.
    for (int i = 0; i < 5; i++) begin
      if (i == 4) rst_n = 1'b0;
      drive_word((i == 0) ? {MAC_ME[23:16], MAC_ME[31:24], MAC_ME[39:32], MAC_ME[47:40]}
                 : (i == 1) ? {16'h1234, MAC_ME[7:0], MAC_ME[15:8]} : $urandom,
                 4'hF, 1'b0, 1'b0);
    end
    check_val("mrst_valid", 64'(b_valid), 64'd0);
    check_val("mrst_stats", 64'({b_ok, b_crc, b_addr, b_ovf}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(MAC_ME, 9, 4'b0111, 1'b1, 1'b1);
    wait_drain();
    check_val("mrst_ok", 64'(b_ok), 64'd1);

    // Overflow on the 16-word instance with the output stalled.
    sel_small = 1'b1;
    out_ready = 1'b0;
    send_frame(MAC_ME, 10, 4'hF, 1'b1, 1'b1);
    send_frame(MAC_ME, 10, 4'hF, 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    check_val("ovf_cnt", 64'(s_ovf), 64'd1);
    check_val("ovf_ok", 64'(s_ok), 64'd1);
    check_val("ovf_crc", 64'(s_crc), 64'd0);
    check_val("ovf_valid", 64'(s_valid), 64'd1);
    check_val("hold_data", 64'(s_data), 64'(sb[0][31:0]));
    repeat (3) @(posedge clk); #1;
    check_val("hold_data2", 64'(s_data), 64'(sb[0][31:0]));
    out_ready = 1'b1;
    wait_drain();
    check_val("big_quiet", 64'(b_ok), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
